// File: rtl/riscv_pkg.sv
// Shared core parameters and the instruction-memory loader state encoding.
package riscv_pkg;

    localparam int XLEN            = 32;
    localparam int ALEN            = 32;
    localparam int RAM_MEMORY_SIZE = 256;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into one word; field_done flags the
// transfer that supplies the top byte, with field_word valid in that cycle.
module byte_packer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            take,
    input  logic [7:0]      byte_data,
    output logic            field_done,
    output logic [XLEN-1:0] field_word
);

    logic [1:0]  cnt;
    logic [23:0] low_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= 2'd0;
            low_q <= 24'd0;
        end else if (take) begin
            cnt <= cnt + 2'd1;
            case (cnt)
                2'd0:    low_q[7:0]   <= byte_data;
                2'd1:    low_q[15:8]  <= byte_data;
                2'd2:    low_q[23:16] <= byte_data;
                default: low_q        <= low_q;
            endcase
        end
    end

    // The top byte bypasses the register so the word is usable on its own edge.
    assign field_done = take && (cnt == 2'd3);
    assign field_word = {byte_data, low_q};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed program image into instruction
// memory and holds the core in reset until a good image has landed.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int unsigned     MAX_WORDS = RAM_MEMORY_SIZE,
    parameter logic [ALEN-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            mem_we,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            cpu_hold,
    output logic            done,
    output logic            error,
    output loader_state_t   dbg_state
);

    // Handshake: a byte moves on every rising edge where byte_valid and
    // byte_ready are both high; byte_valid alone has no effect on any state.
    loader_state_t   state, state_next;
    logic            take, restart, field_done;
    logic [XLEN-1:0] field_word, len_q, index, csum;

    assign take      = byte_valid && byte_ready;
    assign restart   = start && (state == IDLE || state == DONE || state == ERR);
    assign dbg_state = state;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart),
        .take       (take),
        .byte_data  (byte_data),
        .field_done (field_done),
        .field_word (field_word)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_next = LEN;
            LEN: if (field_done) begin
                if (field_word == '0)                    state_next = CSUM;
                else if (field_word > XLEN'(MAX_WORDS))  state_next = ERR;
                else                                     state_next = DATA;
            end
            DATA: if (field_done && index == len_q - 1'b1) state_next = CSUM;
            CSUM: if (field_done) state_next = (field_word == csum) ? DONE : ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            index      <= '0;
            csum       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            byte_ready <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            state      <= state_next;
            mem_we     <= 1'b0;
            byte_ready <= (state_next == LEN) || (state_next == DATA) || (state_next == CSUM);
            done       <= (state_next == DONE);
            error      <= (state_next == ERR);
            cpu_hold   <= (state_next != DONE);
            if (restart) begin
                csum  <= '0;
                index <= '0;
            end
            if (state == LEN && field_done) begin
                len_q <= field_word;
                index <= '0;
            end
            // Word writes land one cycle after the completing byte.
            if (state == DATA && field_done) begin
                mem_we    <= 1'b1;
                mem_wdata <= field_word;
                mem_addr  <= BASE_ADDR + (ALEN'(index) << 2);
                csum      <= csum + field_word;
                index     <= index + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes are queued as bytes
// are driven and popped by a write monitor.
module tb_imem_loader;
  import riscv_pkg::*;

  localparam int unsigned MAXW = 16;

  logic            clk = 1'b0;
  logic            rst, start, byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready, mem_we, cpu_hold, done, error;
  logic [ALEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  loader_state_t   dbg_state;

  int errors = 0;
  int checks = 0;
  int n_writes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [31:0] words [0:31];

  imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR('0)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // scoreboard: every mem_we cycle must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we) begin
      n_writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_exp) begin
          errors++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
    int unsigned gap;
    int waited;
    gap = $urandom_range(0, gap_max);
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    waited     = 0;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      waited++;
      if (waited > 40) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: byte_ready=0 for %0d cycles, required 1", waited);
        break;
      end
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_field(input logic [31:0] w, input int unsigned gap_max);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_max);
  endtask

  // n words from words[], then either the true sum or a forced checksum
  task automatic run_load(input int n, input bit force_csum, input logic [31:0] csum_val,
                          input int unsigned gap_max, input int start_at);
    logic [31:0] sum;
    sum = '0;
    send_field(32'(n), gap_max);
    for (int i = 0; i < n; i++) begin
      if (i == start_at) pulse_start();
      exp_q.push_back({32'(i) << 2, words[i]});
      sum = sum + words[i];
      send_field(words[i], gap_max);
    end
    send_field(force_csum ? csum_val : sum, gap_max);
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_error,
                              input logic e_hold);
    @(negedge clk);
    checks++;
    if ({done, error, cpu_hold, byte_ready} !== {e_done, e_error, e_hold, 1'b0}) begin
      errors++;
      $display("FAIL %s: done=%b error=%b cpu_hold=%b byte_ready=%b, required %b %b %b 0",
               tag, done, error, cpu_hold, byte_ready, e_done, e_error, e_hold);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d writes missing, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = 8'hFF;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mem: we=%b addr=%h data=%h, required 0 0 0", mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({byte_ready, done, error, cpu_hold} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ctrl: ready/done/error/hold=%b, required 0001",
               {byte_ready, done, error, cpu_hold});
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d, required %0d", dbg_state, IDLE);
    end
    tick();
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_ready: byte_ready=%b, required 0", byte_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    pulse_start();
    run_load(2, 1'b1, 32'h0010_00A6, 0, -1);
    check_status("basic", 1'b1, 1'b0, 1'b0);
    checks++;
    if ({mem_addr, mem_wdata} !== {32'h4, 32'h0010_0093}) begin
      errors++;
      $display("FAIL basic_hold: addr=%h data=%h, required 00000004 00100093", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_zero_len();
    int w0;
    w0 = n_writes;
    pulse_start();
    run_load(0, 1'b1, 32'h0, 1, -1);
    check_status("zero_len", 1'b1, 1'b0, 1'b0);
    checks++;
    if (n_writes != w0) begin
      errors++;
      $display("FAIL zero_len_writes: %0d writes, required 0", n_writes - w0);
    end
  endtask

  task automatic test_too_long();
    int w0;
    w0 = n_writes;
    pulse_start();
    send_field(32'(MAXW + 1), 0);
    check_status("too_long", 1'b0, 1'b1, 1'b1);
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({byte_ready, error} !== 2'b01) begin
        errors++;
        $display("FAIL too_long_stall: byte_ready=%b error=%b, required 0 1", byte_ready, error);
      end
      tick();
    end
    byte_valid = 1'b0;
    checks++;
    if (n_writes != w0) begin
      errors++;
      $display("FAIL too_long_writes: %0d writes, required 0", n_writes - w0);
    end
  endtask

  task automatic test_bad_csum();
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    pulse_start();
    run_load(2, 1'b1, 32'hDEAD_BEEF, 1, -1);
    check_status("bad_csum", 1'b0, 1'b1, 1'b1);
    pulse_start();
    run_load(2, 1'b0, 32'h0, 1, -1);
    check_status("bad_csum_retry", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = n_writes;
    words[0] = 32'h1122_3344;
    words[1] = 32'hA5A5_0F0F;
    pulse_start();
    send_field(32'd2, 0);
    send_byte(8'h44, 0);
    send_byte(8'h33, 0);
    rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h22;
    tick();
    rst = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({dbg_state == IDLE, byte_ready, cpu_hold, done} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_mid: state=%0d ready=%b hold=%b done=%b, required IDLE 0 1 0",
               dbg_state, byte_ready, cpu_hold, done);
    end
    checks++;
    if (n_writes != w0) begin
      errors++;
      $display("FAIL reset_mid_writes: %0d writes, required 0", n_writes - w0);
    end
    tick();
    pulse_start();
    run_load(2, 1'b0, 32'h0, 0, -1);
    check_status("reset_mid_reload", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = n_writes;
    for (int i = 0; i < int'(MAXW); i++) words[i] = $urandom();
    pulse_start();
    run_load(int'(MAXW), 1'b0, 32'h0, 3, 5);
    check_status("random_max", 1'b1, 1'b0, 1'b0);
    checks++;
    if (n_writes - w0 != int'(MAXW)) begin
      errors++;
      $display("FAIL random_count: %0d writes, required %0d", n_writes - w0, MAXW);
    end
    checks++;
    if (mem_addr !== 32'h3C) begin
      errors++;
      $display("FAIL random_last_addr: addr=%h, required 0000003c", mem_addr);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_too_long();
    test_bad_csum();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
